// File: rtl/mips_mem_pkg.sv
// Memory-stage shared definitions: drain FSM encoding, byte-enable patterns,
// default store-buffer depth and the word-address helper.
package mips_mem_pkg;

   localparam int SB_DEPTH_DEFAULT = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } sb_state_t;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_BYTE1   = 4'b0010;
   localparam logic [3:0] BE_BYTE2   = 4'b0100;
   localparam logic [3:0] BE_BYTE3   = 4'b1000;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-request / data-memory write bundle for the store buffer.
// slave = the store buffer itself, master = pipeline plus memory environment.
interface store_buffer_if
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT
) ();

   logic                    st_valid;
   logic                    st_ready;
   logic [31:0]             st_addr;
   logic [31:0]             st_wdata;
   logic [3:0]              st_be;
   logic                    bus_req;
   logic                    bus_ack;
   logic [31:0]             bus_addr;
   logic [31:0]             bus_wdata;
   logic [3:0]              bus_be;
   logic                    sb_empty;
   logic [$clog2(DEPTH):0]  sb_count;

   modport slave (
      input  st_valid, st_addr, st_wdata, st_be, bus_ack,
      output st_ready, bus_req, bus_addr, bus_wdata, bus_be, sb_empty, sb_count
   );

   modport master (
      output st_valid, st_addr, st_wdata, st_be, bus_ack,
      input  st_ready, bus_req, bus_addr, bus_wdata, bus_be, sb_empty, sb_count
   );

endinterface

// File: rtl/store_buffer_lane_align.sv
// Replicates sub-word store data onto every byte lane so the enabled lanes
// carry the right bytes regardless of the address offset.
module store_lane_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] i_st_wdata,
   input  logic [3:0]  i_st_be,
   output logic [31:0] o_aligned
);

   always_comb begin
      o_aligned = i_st_wdata;
      case (i_st_be)
         BE_HALF_LO, BE_HALF_HI:                    o_aligned = {2{i_st_wdata[15:0]}};
         BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3:    o_aligned = {4{i_st_wdata[7:0]}};
         default:                                   o_aligned = i_st_wdata;
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: FIFO of aligned stores drained to data memory with
// a req/ack handshake. Optional tail merging is built when STORE_BUFFER_MERGE_EN is defined.
module store_buffer
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          reset_n,
   store_buffer_if.slave sb_if
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   r_ent_addr [DEPTH];
   logic [31:0]   r_ent_data [DEPTH];
   logic [3:0]    r_ent_be   [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   sb_state_t     r_state;
   logic          r_bus_req;
   logic [31:0]   r_bus_addr;
   logic [31:0]   r_bus_wdata;
   logic [3:0]    r_bus_be;

   logic [31:0]   w_word_addr;
   logic [31:0]   w_aligned;
   logic          w_push;
   logic          w_pop;
   logic          w_append;
   logic [PW-1:0] w_wr_idx;
   logic [31:0]   w_wr_data;
   logic [3:0]    w_wr_be;
   logic [PW-1:0] w_wptr_next;
   logic [PW-1:0] w_rptr_next;
   logic [CW-1:0] w_count_next;
   sb_state_t     w_state_next;
   logic          w_bus_req_next;
   logic [31:0]   w_bus_addr_next;
   logic [31:0]   w_bus_wdata_next;
   logic [3:0]    w_bus_be_next;

   store_lane_align u_align (
      .i_st_wdata (sb_if.st_wdata),
      .i_st_be    (sb_if.st_be),
      .o_aligned  (w_aligned)
   );

   assign w_word_addr    = word_addr(sb_if.st_addr);
   assign sb_if.st_ready = (r_count != CW'(DEPTH));
   // A zero byte-enable store is handshaken but never occupies an entry.
   assign w_push         = sb_if.st_valid && sb_if.st_ready && (sb_if.st_be != 4'b0000);
   assign w_pop          = (r_state == ST_REQ) && sb_if.bus_ack;

`ifdef STORE_BUFFER_MERGE_EN
   logic [PW-1:0] w_tail;
   logic          w_merge;
   logic [31:0]   w_merge_data;

   // The tail may absorb a same-word store unless it is already on the bus.
   assign w_tail  = r_wptr - 1'b1;
   assign w_merge = w_push && (r_count != '0) && (r_ent_addr[w_tail] == w_word_addr)
                    && !(r_bus_req && (w_tail == r_rptr));

   // Lanes enabled by neither store are cleared so stale replicas never reach memory.
   for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
      assign w_merge_data[8*gi +: 8] = sb_if.st_be[gi]         ? w_aligned[8*gi +: 8] :
                                       r_ent_be[w_tail][gi]    ? r_ent_data[w_tail][8*gi +: 8] :
                                                                 8'h00;
   end

   assign w_append  = w_push && !w_merge;
   assign w_wr_idx  = w_merge ? w_tail : r_wptr;
   assign w_wr_data = w_merge ? w_merge_data : w_aligned;
   assign w_wr_be   = w_merge ? (r_ent_be[w_tail] | sb_if.st_be) : sb_if.st_be;
`else
   assign w_append  = w_push;
   assign w_wr_idx  = r_wptr;
   assign w_wr_data = w_aligned;
   assign w_wr_be   = sb_if.st_be;
`endif

   assign w_wptr_next  = r_wptr + PW'(w_append);
   assign w_rptr_next  = r_rptr + PW'(w_pop);
   assign w_count_next = r_count + CW'(w_append) - CW'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ent_addr[w_wr_idx] <= w_word_addr;
         r_ent_data[w_wr_idx] <= w_wr_data;
         r_ent_be[w_wr_idx]   <= w_wr_be;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_bus_req   <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_be    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_wptr      <= w_wptr_next;
         r_rptr      <= w_rptr_next;
         r_count     <= w_count_next;
         r_bus_req   <= w_bus_req_next;
         r_bus_addr  <= w_bus_addr_next;
         r_bus_wdata <= w_bus_wdata_next;
         r_bus_be    <= w_bus_be_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_count_next != '0) w_state_next = ST_REQ;
         ST_REQ:  if (w_pop && (w_count_next == '0)) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Outputs are loaded with next cycle's head; the entry being written this cycle
   // is forwarded so an empty-buffer push is presented one cycle later.
   always_comb begin
      w_bus_req_next   = 1'b0;
      w_bus_addr_next  = '0;
      w_bus_wdata_next = '0;
      w_bus_be_next    = '0;
      if (w_state_next == ST_REQ) begin
         w_bus_req_next = 1'b1;
         if (w_push && (w_wr_idx == w_rptr_next)) begin
            w_bus_addr_next  = w_word_addr;
            w_bus_wdata_next = w_wr_data;
            w_bus_be_next    = w_wr_be;
         end else begin
            w_bus_addr_next  = r_ent_addr[w_rptr_next];
            w_bus_wdata_next = r_ent_data[w_rptr_next];
            w_bus_be_next    = r_ent_be[w_rptr_next];
         end
      end
   end

   assign sb_if.bus_req   = r_bus_req;
   assign sb_if.bus_addr  = r_bus_addr;
   assign sb_if.bus_wdata = r_bus_wdata;
   assign sb_if.bus_be    = r_bus_be;
   assign sb_if.sb_empty  = (r_count == '0);
   assign sb_if.sb_count  = r_count;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected bus writes are queued as stores are
// driven and compared against the bus each time the head is acknowledged.
module tb_store_buffer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   ent_t exp_q[$];

   store_buffer_if #(.DEPTH(DEPTH)) sb_if ();

   store_buffer #(.DEPTH(DEPTH)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sb_if   (sb_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] f_align(input logic [31:0] d, input logic [3:0] be);
      case (be)
         4'b0011, 4'b1100:                   return {d[15:0], d[15:0]};
         4'b0001, 4'b0010, 4'b0100, 4'b1000: return {d[7:0], d[7:0], d[7:0], d[7:0]};
         default:                            return d;
      endcase
   endfunction

   // Tail merge is only legal when the tail is not the entry on the bus (queue size >= 2).
   task automatic model_add(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      ent_t e;
      ent_t t;
      e.addr = {a[31:2], 2'b00};
      e.data = f_align(d, be);
      e.be   = be;
      t      = e;
      if (be != 4'b0000) begin
`ifdef STORE_BUFFER_MERGE_EN
         if (exp_q.size() >= 2 && exp_q[exp_q.size()-1].addr == e.addr) begin
            t = exp_q[exp_q.size()-1];
            for (int i = 0; i < 4; i++)
               t.data[8*i +: 8] = be[i] ? e.data[8*i +: 8] : (t.be[i] ? t.data[8*i +: 8] : 8'h00);
            t.be = t.be | be;
            exp_q[exp_q.size()-1] = t;
         end else begin
            exp_q.push_back(e);
         end
`else
         exp_q.push_back(t);
`endif
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int n;
      n = 0;
      sb_if.st_valid = 1'b1;
      sb_if.st_addr  = a;
      sb_if.st_wdata = d;
      sb_if.st_be    = be;
      while (!sb_if.st_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", 32'(sb_if.st_ready), 32'd1);
      @(negedge clk);
      sb_if.st_valid = 1'b0;
      model_add(a, d, be);
      $display("push addr=%08h data=%08h be=%b count=%0d", a, d, be, sb_if.sb_count);
   endtask

   task automatic check_head(input string tag);
      if (exp_q.size() == 0) begin
         chk({tag, "_req_idle"}, 32'(sb_if.bus_req), 32'd0);
      end else begin
         chk({tag, "_req"},   32'(sb_if.bus_req), 32'd1);
         chk({tag, "_addr"},  sb_if.bus_addr,     exp_q[0].addr);
         chk({tag, "_wdata"}, sb_if.bus_wdata,    exp_q[0].data);
         chk({tag, "_be"},    32'(sb_if.bus_be),  32'(exp_q[0].be));
      end
   endtask

   task automatic ack_head(input string tag);
      check_head(tag);
      sb_if.bus_ack = 1'b1;
      @(negedge clk);
      sb_if.bus_ack = 1'b0;
      if (exp_q.size() > 0) begin
         $display("ack  addr=%08h data=%08h be=%b", exp_q[0].addr, exp_q[0].data, exp_q[0].be);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic drain_all(input string tag);
      for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) ack_head(tag);
      chk({tag, "_drained_empty"}, 32'(sb_if.sb_empty), 32'd1);
      chk({tag, "_drained_req"},   32'(sb_if.bus_req),  32'd0);
   endtask

   initial begin
      sb_if.st_valid = 1'b0;
      sb_if.st_addr  = '0;
      sb_if.st_wdata = '0;
      sb_if.st_be    = '0;
      sb_if.bus_ack  = 1'b0;
      reset_n        = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_bus_req",   32'(sb_if.bus_req),  32'd0);
      chk("rst_bus_addr",  sb_if.bus_addr,      32'd0);
      chk("rst_bus_wdata", sb_if.bus_wdata,     32'd0);
      chk("rst_bus_be",    32'(sb_if.bus_be),   32'd0);
      chk("rst_st_ready",  32'(sb_if.st_ready), 32'd1);
      chk("rst_sb_empty",  32'(sb_if.sb_empty), 32'd1);
      chk("rst_sb_count",  32'(sb_if.sb_count), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single byte store: presented on the very next cycle, replicated on all lanes.
      push(32'h0000_1002, 32'h0000_00AB, 4'b0100);
      chk("sb_req",   32'(sb_if.bus_req), 32'd1);
      chk("sb_addr",  sb_if.bus_addr,     32'h0000_1000);
      chk("sb_wdata", sb_if.bus_wdata,    32'hABAB_ABAB);
      chk("sb_be",    32'(sb_if.bus_be),  32'h4);
      ack_head("sb");
      chk("sb_idle_empty", 32'(sb_if.sb_empty), 32'd1);
      chk("sb_idle_addr",  sb_if.bus_addr,      32'd0);

      // Zero byte-enable store is discarded; stray ack while idle is ignored.
      push(32'h0000_2000, 32'h1122_3344, 4'b0000);
      chk("be0_empty", 32'(sb_if.sb_empty), 32'd1);
      chk("be0_req",   32'(sb_if.bus_req),  32'd0);
      sb_if.bus_ack = 1'b1;
      @(negedge clk);
      sb_if.bus_ack = 1'b0;
      chk("idle_ack_req",   32'(sb_if.bus_req),  32'd0);
      chk("idle_ack_count", 32'(sb_if.sb_count), 32'd0);

      // Fill to DEPTH, hold a fifth store, free one slot with an ack.
      push(32'h0000_0100, 32'hA0A0_A0A0, 4'b1111);
      push(32'h0000_0106, 32'h0000_BEEF, 4'b1100);
      push(32'h0000_0109, 32'h0000_005A, 4'b0010);
      push(32'h0000_010C, 32'h0123_4567, 4'b0101);
      chk("full_ready", 32'(sb_if.st_ready), 32'd0);
      chk("full_count", 32'(sb_if.sb_count), 32'd4);
      sb_if.st_valid = 1'b1;
      sb_if.st_addr  = 32'h0000_0110;
      sb_if.st_wdata = 32'hCAFE_F00D;
      sb_if.st_be    = 4'b1111;
      @(negedge clk);
      chk("held_ready", 32'(sb_if.st_ready), 32'd0);
      chk("held_count", 32'(sb_if.sb_count), 32'd4);
      check_head("full");
      sb_if.bus_ack = 1'b1;
      @(negedge clk);
      sb_if.bus_ack = 1'b0;
      void'(exp_q.pop_front());
      chk("freed_ready", 32'(sb_if.st_ready), 32'd1);
      chk("freed_count", 32'(sb_if.sb_count), 32'd3);
      @(negedge clk);
      sb_if.st_valid = 1'b0;
      model_add(32'h0000_0110, 32'hCAFE_F00D, 4'b1111);
      chk("fifth_count", 32'(sb_if.sb_count), 32'd4);
      drain_all("full");

      // Push and pop in the same cycle at count 2, six stores across pointer wrap.
      push(32'h0000_0200, 32'h0000_0001, 4'b1111);
      push(32'h0000_0204, 32'h0000_0002, 4'b1111);
      chk("pp_count_before", 32'(sb_if.sb_count), 32'd2);
      check_head("pp");
      sb_if.bus_ack  = 1'b1;
      sb_if.st_valid = 1'b1;
      sb_if.st_addr  = 32'h0000_0208;
      sb_if.st_wdata = 32'h0000_0003;
      sb_if.st_be    = 4'b1111;
      @(negedge clk);
      sb_if.bus_ack  = 1'b0;
      sb_if.st_valid = 1'b0;
      void'(exp_q.pop_front());
      model_add(32'h0000_0208, 32'h0000_0003, 4'b1111);
      chk("pp_count_after", 32'(sb_if.sb_count), 32'd2);
      check_head("pp_next");
      push(32'h0000_020C, 32'h0000_0004, 4'b1111);
      push(32'h0000_0210, 32'h0000_0005, 4'b1111);
      chk("pp_count_full", 32'(sb_if.sb_count), 32'd4);
      ack_head("pp");
      push(32'h0000_0214, 32'h0000_0006, 4'b1111);
      drain_all("pp");

      // Same-word half + byte behind a busy head on another address.
      push(32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
      push(32'h0000_2000, 32'h0000_1234, 4'b0011);
      push(32'h0000_2003, 32'h0000_0056, 4'b1000);
`ifdef STORE_BUFFER_MERGE_EN
      chk("mg_count", 32'(sb_if.sb_count), 32'd2);
`else
      chk("mg_count", 32'(sb_if.sb_count), 32'd3);
`endif
      ack_head("mg");
`ifdef STORE_BUFFER_MERGE_EN
      chk("mg_wdata", sb_if.bus_wdata,    32'h5600_1234);
      chk("mg_be",    32'(sb_if.bus_be),  32'hB);
`else
      chk("mg_wdata", sb_if.bus_wdata,    32'h1234_1234);
      chk("mg_be",    32'(sb_if.bus_be),  32'h3);
`endif
      drain_all("mg");

      // A tail already on the bus must never absorb a later store.
      push(32'h0000_4000, 32'hAAAA_5555, 4'b1111);
      push(32'h0000_4001, 32'h0000_0077, 4'b0010);
      chk("busy_tail_count", 32'(sb_if.sb_count), 32'd2);
      drain_all("busy_tail");

      // Reset while a write is on the bus with three entries queued.
      push(32'h0000_0500, 32'h0000_0500, 4'b1111);
      push(32'h0000_0504, 32'h0000_0504, 4'b1111);
      push(32'h0000_0508, 32'h0000_0508, 4'b1111);
      chk("mid_rst_req_before", 32'(sb_if.bus_req), 32'd1);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_req",   32'(sb_if.bus_req),  32'd0);
      chk("mid_rst_count", 32'(sb_if.sb_count), 32'd0);
      chk("mid_rst_empty", 32'(sb_if.sb_empty), 32'd1);
      chk("mid_rst_addr",  sb_if.bus_addr,      32'd0);
      @(negedge clk);
      reset_n       = 1'b1;
      sb_if.bus_ack = 1'b1;
      @(negedge clk);
      sb_if.bus_ack = 1'b0;
      chk("post_rst_req",   32'(sb_if.bus_req),  32'd0);
      chk("post_rst_count", 32'(sb_if.sb_count), 32'd0);
      push(32'h0000_0600, 32'h0000_00C3, 4'b0001);
      drain_all("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port st_valid  in  1  store request from MEM stage.
REQ-005 SHALL have port st_ready  out  1  buffer can accept a store.
REQ-006 SHALL have port st_addr  in  32  store byte address.
REQ-007 SHALL have port st_wdata  in  32  unaligned register data.
REQ-008 SHALL have port st_be  in  4  byte enables from the byte-enable generator.
REQ-009 SHALL have port bus_req  out  1  write request to data memory.
REQ-010 SHALL have port bus_ack  in  1  memory accepted current write.
REQ-011 SHALL have ports bus_addr  out  32, bus_wdata  out  32, bus_be  out  4  for the presented write; bus_addr[1:0]=0.
REQ-012 SHALL have ports sb_empty  out  1 and sb_count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-013 Push SHALL occur on st_valid&&st_ready with st_be!=0; st_be==0 is accepted and discarded without creating an entry.
REQ-014 st_ready SHALL be !full, combinational from occupancy only; it does not depend on a same-cycle pop.
REQ-015 Entry word address SHALL be {st_addr[31:2],2'b00}.
REQ-016 Lane alignment: be 1111 -> data unchanged; be 0011/1100 -> {h,h} with h=st_wdata[15:0]; one-hot be -> {b,b,b,b} with b=st_wdata[7:0]; other patterns stored unchanged.
REQ-017 Entries SHALL drain in FIFO order; read/write pointers wrap modulo DEPTH.
REQ-018 Drain FSM SHALL have states IDLE and REQ; IDLE->REQ when count>0; REQ->IDLE on bus_ack when the popped entry was the last.
REQ-019 In REQ, bus_req SHALL be 1 and bus_addr/bus_wdata/bus_be SHALL hold the head entry, stable until bus_ack.
REQ-020 bus_ack in REQ SHALL pop the head; the next entry, if any, is presented the following cycle with bus_req held high.
REQ-021 bus_ack while bus_req=0 SHALL be ignored.
REQ-022 Latency: push into empty buffer SHALL give bus_req=1 on the next cycle.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 Outputs SHALL be registered; in IDLE bus_addr/bus_wdata/bus_be SHALL be 0.

Reset
REQ-025 reset_n low SHALL immediately force bus_req=0, bus_addr=0, bus_wdata=0, bus_be=0, st_ready=1, sb_empty=1, sb_count=0, FSM=IDLE, pointers=0.
REQ-026 Reset mid-transaction SHALL discard all entries, including the one on the bus; no later bus_ack affects state.

Configuration
REQ-027 Macro STORE_BUFFER_MERGE_EN defined: a push whose word address equals the tail entry's, and whose tail is not the entry currently presented with bus_req=1, SHALL merge into the tail: enabled lanes overwrite data, be ORed, count unchanged.
REQ-028 Macro undefined: every accepted push SHALL append a new entry; no merge logic is compiled.

Structure
REQ-029 Shared package mips_mem_pkg SHALL hold FSM state encodings, BE constants (BE_WORD, BE_HALF_LO, BE_HALF_HI, BE_BYTE0..3) and default DEPTH.
REQ-030 Lane alignment SHALL be a combinational sub-module store_lane_align (st_wdata, st_be -> aligned data).

Verification
REQ-031 sb: st_addr=0x1002, st_wdata=0x000000AB, st_be=0100 -> next cycle bus_req=1, bus_addr=0x1000, bus_wdata=0xABABABAB, bus_be=0100.
REQ-032 4 pushes with bus_ack=0 -> st_ready=0, sb_count=4; 5th store held; one bus_ack -> st_ready=1 next cycle, 5th accepted.
REQ-033 Push+ack same cycle at count=2 -> count stays 2; 6 total pushes drained in exact order across pointer wrap.
REQ-034 Head busy on other address; sh 0x2000 data 0x1234 be 0011, then sb 0x2003 data 0x56 be 1000 -> with STORE_BUFFER_MERGE_EN one entry bus_wdata=0x56001234, bus_be=1011; without it, two entries.
REQ-035 reset_n low while bus_req=1 with 3 entries -> bus_req=0 immediately, sb_count=0, sb_empty=1; later bus_ack has no effect.
REQ-036 st_valid with st_be=0000 on empty buffer -> sb_empty stays 1, bus_req stays 0.
